// File: rtl/hpd_pkg.sv
// hpd_pkg: event codes and FIFO entry layout shared by hpd_event_ctrl and its FIFO.
// The entry carries a timestamp field only when HPD_EVT_TIMESTAMP_EN is defined.
package hpd_pkg;
    localparam int TS_W = 32;
    typedef enum logic [1:0] {EVT_NONE, EVT_PLUG, EVT_UNPLUG, EVT_IRQ} hpd_evt_e;
`ifdef HPD_EVT_TIMESTAMP_EN
    typedef struct packed {
        hpd_evt_e         code;
        logic [TS_W-1:0]  ts;
    } hpd_entry_t;
`else
    typedef struct packed {
        hpd_evt_e code;
    } hpd_entry_t;
`endif
endpackage

// File: rtl/hpd_evt_if.sv
// hpd_evt_if: valid/ready event channel from hpd_event_ctrl to the link policy controller.
// Signals: evt_valid, evt_code, evt_timestamp (producer -> consumer), evt_ready (consumer -> producer).
interface hpd_evt_if #(parameter int TS_WIDTH = 32);
    import hpd_pkg::*;
    logic                evt_valid;
    logic                evt_ready;
    hpd_evt_e            evt_code;
    logic [TS_WIDTH-1:0] evt_timestamp;
    modport master (output evt_valid, evt_code, evt_timestamp, input evt_ready);
    modport slave  (input evt_valid, evt_code, evt_timestamp, output evt_ready);
endinterface

// File: rtl/hpd_evt_fifo.sv
// hpd_evt_fifo: synchronous FIFO of hpd_entry_t with push/pop/full/empty.
// Ports: clk, rst (sync, active high), push_i/din_i, pop_i/dout_o (head), full_o, empty_o.
// A push while full is accepted only if a pop happens in the same cycle.
module hpd_evt_fifo
    import hpd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  hpd_entry_t din_i,
    input  logic       pop_i,
    output hpd_entry_t dout_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);
    hpd_entry_t  mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic        do_pop, do_push;
    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = wr_q == rd_q;
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign dout_o  = mem_q[rd_q[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            mem_q <= '{default: '0};
        end else begin
            if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop) rd_q <= rd_q + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/hpd_event_ctrl.sv
// hpd_event_ctrl: turns HPD detector levels into queued PLUG/UNPLUG/IRQ events.
// Ports: clk, rst (sync, active high), hpd_detect, hpd_irq, ovf_clr,
//        evt (hpd_evt_if.master: evt_valid/evt_code/evt_timestamp/evt_ready),
//        hpd_connected, evt_overflow (sticky), irq_count (saturating).
// Macro HPD_EVT_TIMESTAMP_EN: stamps each entry with a free-running cycle counter;
// without it evt_timestamp is tied to 0.
module hpd_event_ctrl
    import hpd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int TS_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hpd_detect,
    input  logic                 hpd_irq,
    input  logic                 ovf_clr,
    hpd_evt_if.master            evt,
    output logic                 hpd_connected,
    output logic                 evt_overflow,
    output logic [CNT_WIDTH-1:0] irq_count
);
    logic                 det_q, irq_q, pend_q, ovf_q;
    logic                 pend_d, ovf_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 plug, unplug, irq_edge, irq_ok, pend_ok;
    logic                 push, pop, full, empty, accept;
    hpd_evt_e             code;
    hpd_entry_t           din, head;
    assign plug     = hpd_detect & ~det_q;
    assign unplug   = ~hpd_detect & det_q;
    assign irq_edge = hpd_irq & ~irq_q;
    assign irq_ok   = irq_edge & det_q & hpd_detect;
    // A deferred IRQ only survives if the link is still connected.
    assign pend_ok  = pend_q & hpd_detect;
    // Detect events win; a pending IRQ and a fresh IRQ edge collapse into one push.
    assign code     = plug ? EVT_PLUG : unplug ? EVT_UNPLUG : (pend_ok | irq_ok) ? EVT_IRQ : EVT_NONE;
    assign push     = code != EVT_NONE;
    assign pop      = evt.evt_valid & evt.evt_ready;
    assign accept   = push & (~full | pop);
    always_comb begin
        pend_d = plug & irq_edge;
        ovf_d  = (push & full & ~pop) | (ovf_q & ~ovf_clr);
        cnt_d  = (accept && code == EVT_IRQ && !(&cnt_q)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            det_q  <= 1'b0;
            irq_q  <= 1'b0;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            det_q  <= hpd_detect;
            irq_q  <= hpd_irq;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
        end
    end
`ifdef HPD_EVT_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q;
    always_ff @(posedge clk) begin
        if (rst) ts_q <= '0;
        else ts_q <= ts_q + TS_WIDTH'(1);
    end
    always_comb begin
        din      = '0;
        din.code = code;
        din.ts   = TS_W'(ts_q);
    end
    assign evt.evt_timestamp = evt.evt_valid ? TS_WIDTH'(head.ts) : {TS_WIDTH{1'b0}};
`else
    always_comb begin
        din      = '0;
        din.code = code;
    end
    assign evt.evt_timestamp = {TS_WIDTH{1'b0}};
`endif
    hpd_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (din),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );
    assign evt.evt_valid = ~empty;
    assign evt.evt_code  = evt.evt_valid ? head.code : EVT_NONE;
    assign hpd_connected = det_q;
    assign evt_overflow  = ovf_q;
    assign irq_count     = cnt_q;
endmodule
